div_iter: RTL and testbench

//  Multi-cycle iterative restoring divider: WIDTH-bit dividend / WIDTH-bit divisor -> quotient + remainder.

---
 rtl/div_iter_if.sv | 26 ++
 rtl/div_iter.sv | 141 ++++++++++++++
 tb/tb_div_iter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// div_iter_if: valid/ready operand and result bundle for div_iter.
// master = issuing/consuming side, slave = the divider.
interface div_iter_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, in_signed, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, in_signed, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, STEPS quotient bits per clock.
// Ports: clk, rst (sync, active high), bus (div_iter_if.slave).
module div_iter #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input logic       clk,
    input logic       rst,
    div_iter_if.slave bus
);
    localparam int N  = WIDTH / STEPS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    // dividend bits leave at the MSB while quotient bits enter at the LSB
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_acc;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        step_rem = rem_q;
        step_acc = acc_q;
        for (int i = 0; i < STEPS; i++) begin
            step_rem = {step_rem[WIDTH-1:0], step_acc[WIDTH-1]};
            step_acc = {step_acc[WIDTH-2:0], 1'b0};
            if (step_rem >= {1'b0, dvs_q}) begin
                step_rem    = step_rem - {1'b0, dvs_q};
                step_acc[0] = 1'b1;
            end
        end
    end

    // magnitude of MIN wraps to 2^(WIDTH-1), which is correct unsigned
    assign a_neg = bus.in_signed & bus.dividend[WIDTH-1];
    assign b_neg = bus.in_signed & bus.divisor[WIDTH-1];
    assign a_mag = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag = b_neg ? -bus.divisor : bus.divisor;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        acc_d         = acc_q;
        dvs_d         = dvs_q;
        qneg_d        = qneg_q;
        rneg_d        = rneg_q;
        quo_d         = quo_q;
        rmd_d         = rmd_q;
        dbz_d         = dbz_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    rem_d   = '0;
                    acc_d   = a_mag;
                    dvs_d   = b_mag;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    cnt_d   = CW'(N);
                    state_d = CALC;
                    // zero divisor: one pass through CALC, raw dividend kept
                    if (bus.divisor == '0) begin
                        acc_d = bus.dividend;
                        cnt_d = CW'(1);
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                acc_d = step_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    if (dvs_q == '0) begin
                        quo_d = '1;
                        rmd_d = acc_q;
                        dbz_d = 1'b1;
                    end else begin
                        quo_d = qneg_q ? -step_acc : step_acc;
                        rmd_d = rneg_q ? -step_rem[WIDTH-1:0]
                                       : step_rem[WIDTH-1:0];
                        dbz_d = 1'b0;
                    end
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and randomized checks of div_iter.
// DUT 0: 32/1, 1: 32/4, 2: 8/1, 3: 8/4 (WIDTH/STEPS).
module tb_div_iter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    div_iter_if #(.WIDTH(32)) b0 ();
    div_iter_if #(.WIDTH(32)) b1 ();
    div_iter_if #(.WIDTH(8))  b2 ();
    div_iter_if #(.WIDTH(8))  b3 ();

    div_iter #(.WIDTH(32), .STEPS(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    div_iter #(.WIDTH(32), .STEPS(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
    div_iter #(.WIDTH(8),  .STEPS(1)) u2 (.clk(clk), .rst(rst), .bus(b2));
    div_iter #(.WIDTH(8),  .STEPS(4)) u3 (.clk(clk), .rst(rst), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(input int s);
        return (s < 2) ? 32 : 8;
    endfunction

    function automatic int iters(input int s);
        case (s)
            0: return 32;
            1: return 8;
            2: return 8;
            default: return 2;
        endcase
    endfunction

    function automatic logic obs_ir(input int s);
        case (s)
            0: return b0.in_ready;
            1: return b1.in_ready;
            2: return b2.in_ready;
            default: return b3.in_ready;
        endcase
    endfunction

    function automatic logic obs_ov(input int s);
        case (s)
            0: return b0.out_valid;
            1: return b1.out_valid;
            2: return b2.out_valid;
            default: return b3.out_valid;
        endcase
    endfunction

    function automatic logic obs_z(input int s);
        case (s)
            0: return b0.div_by_zero;
            1: return b1.div_by_zero;
            2: return b2.div_by_zero;
            default: return b3.div_by_zero;
        endcase
    endfunction

    function automatic logic [31:0] obs_q(input int s);
        case (s)
            0: return b0.quotient;
            1: return b1.quotient;
            2: return 32'(b2.quotient);
            default: return 32'(b3.quotient);
        endcase
    endfunction

    function automatic logic [31:0] obs_r(input int s);
        case (s)
            0: return b0.remainder;
            1: return b1.remainder;
            2: return 32'(b2.remainder);
            default: return 32'(b3.remainder);
        endcase
    endfunction

    task automatic drive(input int s, input logic v, input logic sg,
                         input logic [31:0] a, input logic [31:0] b);
        case (s)
            0: begin
                b0.in_valid = v; b0.in_signed = sg;
                b0.dividend = a; b0.divisor = b;
            end
            1: begin
                b1.in_valid = v; b1.in_signed = sg;
                b1.dividend = a; b1.divisor = b;
            end
            2: begin
                b2.in_valid = v; b2.in_signed = sg;
                b2.dividend = a[7:0]; b2.divisor = b[7:0];
            end
            default: begin
                b3.in_valid = v; b3.in_signed = sg;
                b3.dividend = a[7:0]; b3.divisor = b[7:0];
            end
        endcase
    endtask

    task automatic set_ordy(input int s, input logic v);
        case (s)
            0: b0.out_ready = v;
            1: b1.out_ready = v;
            2: b2.out_ready = v;
            default: b3.out_ready = v;
        endcase
    endtask

    // Reference: plain integer division on sign-extended values.
    function automatic void ref_div(input int w, input logic sg,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z);
        longint m, ua, ub, sa, sb, qq, rr;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        if (ub == 0) begin
            q = m[31:0];
            r = ua[31:0];
            z = 1'b1;
            return;
        end
        z = 1'b0;
        if (sg) begin
            sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
            sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
            qq = sa / sb;
            rr = sa % sb;
        end else begin
            qq = ua / ub;
            rr = ua % ub;
        end
        qq = qq & m;
        rr = rr & m;
        q  = qq[31:0];
        r  = rr[31:0];
    endfunction

    // Issue one op, wait for result, capture it, then pop it.
    task automatic run_op(input int s, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic z, output int lat, output logic ok);
        int n;
        ok = 1'b1;
        n  = 0;
        set_ordy(s, 1'b0);
        while (!obs_ir(s) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!obs_ir(s)) ok = 1'b0;
        drive(s, 1'b1, sg, a, b);
        @(negedge clk);
        drive(s, 1'b0, $urandom_range(0, 1), $urandom, $urandom);
        lat = 0;
        while (!obs_ov(s) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!obs_ov(s)) ok = 1'b0;
        q = obs_q(s);
        r = obs_r(s);
        z = obs_z(s);
        set_ordy(s, 1'b1);
        @(negedge clk);
        set_ordy(s, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            total++;
            if (obs_ir(s) !== 1'b1 || obs_ov(s) !== 1'b0 || obs_q(s) !== 32'd0 ||
                obs_r(s) !== 32'd0 || obs_z(s) !== 1'b0) begin
                bad++;
                $display("FAIL reset_dut%0d: ir=%b ov=%b q=%h r=%h z=%b, want ir=1 ov=0 q=0 r=0 z=0",
                         s, obs_ir(s), obs_ov(s), obs_q(s), obs_r(s), obs_z(s));
            end
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] q, r;
        logic        z, ok;
        int          lat;
        run_op(0, 1'b0, 32'd100, 32'd7, q, r, z, lat, ok);
        total++;
        if (!ok || q !== 32'd14 || r !== 32'd2 || z !== 1'b0 || lat !== 32) begin
            bad++;
            $display("FAIL unsigned_100_7: q=%h r=%h z=%b lat=%0d, want q=0000000e r=00000002 z=0 lat=32",
                     q, r, z, lat);
        end
    endtask

    task automatic test_signed();
        logic [31:0] q, r;
        logic        z, ok;
        int          lat;
        run_op(0, 1'b1, 32'hFFFFFFF9, 32'h2, q, r, z, lat, ok);
        total++;
        if (!ok || q !== 32'hFFFFFFFD || r !== 32'hFFFFFFFF || z !== 1'b0) begin
            bad++;
            $display("FAIL signed_m7_2: q=%h r=%h z=%b, want q=fffffffd r=ffffffff z=0", q, r, z);
        end
        run_op(0, 1'b0, 32'hFFFFFFF9, 32'h2, q, r, z, lat, ok);
        total++;
        if (!ok || q !== 32'h7FFFFFFC || r !== 32'h1 || z !== 1'b0) begin
            bad++;
            $display("FAIL unsigned_fff9_2: q=%h r=%h z=%b, want q=7ffffffc r=00000001 z=0", q, r, z);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r;
        logic        z, ok;
        int          lat;
        for (int m = 0; m < 2; m++) begin
            run_op(0, m[0], 32'h1234, 32'h0, q, r, z, lat, ok);
            total++;
            if (!ok || q !== 32'hFFFFFFFF || r !== 32'h1234 || z !== 1'b1 || lat !== 1) begin
                bad++;
                $display("FAIL divzero_mode%0d: q=%h r=%h z=%b lat=%0d, want q=ffffffff r=00001234 z=1 lat=1",
                         m, q, r, z, lat);
            end
        end
        run_op(0, 1'b1, 32'h80000000, 32'hFFFFFFFF, q, r, z, lat, ok);
        total++;
        if (!ok || q !== 32'h80000000 || r !== 32'h0 || z !== 1'b0) begin
            bad++;
            $display("FAIL min_div_m1: q=%h r=%h z=%b, want q=80000000 r=00000000 z=0", q, r, z);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q0, r0, q, r;
        logic        z0, z, ok;
        int          n, lat;
        set_ordy(0, 1'b0);
        drive(0, 1'b1, 1'b0, 32'd1000, 32'd3);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, $urandom, $urandom);
        n = 0;
        while (!obs_ov(0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        q0 = obs_q(0);
        r0 = obs_r(0);
        z0 = obs_z(0);
        total++;
        if (obs_ov(0) !== 1'b1 || q0 !== 32'd333 || r0 !== 32'd1 || z0 !== 1'b0) begin
            bad++;
            $display("FAIL bp_first: ov=%b q=%h r=%h z=%b, want ov=1 q=0000014d r=00000001 z=0",
                     obs_ov(0), q0, r0, z0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (obs_ov(0) !== 1'b1 || obs_ir(0) !== 1'b0 || obs_q(0) !== 32'd333 ||
                obs_r(0) !== 32'd1 || obs_z(0) !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b q=%h r=%h, want ov=1 ir=0 q=0000014d r=00000001",
                         i, obs_ov(0), obs_ir(0), obs_q(0), obs_r(0));
            end
        end
        set_ordy(0, 1'b1);
        @(negedge clk);
        set_ordy(0, 1'b0);
        total++;
        if (obs_ir(0) !== 1'b1 || obs_ov(0) !== 1'b0 || obs_z(0) !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: ir=%b ov=%b z=%b, want ir=1 ov=0 z=0",
                     obs_ir(0), obs_ov(0), obs_z(0));
        end
        run_op(0, 1'b0, 32'hFFFFFFFF, 32'h10, q, r, z, lat, ok);
        total++;
        if (!ok || q !== 32'h0FFFFFFF || r !== 32'hF || z !== 1'b0) begin
            bad++;
            $display("FAIL bp_second: q=%h r=%h z=%b, want q=0fffffff r=0000000f z=0", q, r, z);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r;
        logic        z, ok;
        int          lat, n;
        drive(0, 1'b1, 1'b0, 32'd1234, 32'd5);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (obs_ir(0) !== 1'b1 || obs_ov(0) !== 1'b0 || obs_q(0) !== 32'd0 ||
            obs_r(0) !== 32'd0 || obs_z(0) !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: ir=%b ov=%b q=%h r=%h z=%b, want ir=1 ov=0 q=0 r=0 z=0",
                     obs_ir(0), obs_ov(0), obs_q(0), obs_r(0), obs_z(0));
        end
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (obs_ov(0)) n++;
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL midreset_stale: out_valid cycles=%0d, want 0", n);
        end
        run_op(0, 1'b0, 32'd9, 32'd3, q, r, z, lat, ok);
        total++;
        if (!ok || q !== 32'd3 || r !== 32'd0 || z !== 1'b0 || lat !== 32) begin
            bad++;
            $display("FAIL midreset_9_3: q=%h r=%h z=%b lat=%0d, want q=00000003 r=0 z=0 lat=32",
                     q, r, z, lat);
        end
    endtask

    task automatic test_steps4();
        logic [31:0] q, r;
        logic        z, ok;
        int          lat;
        run_op(1, 1'b0, 32'd100, 32'd7, q, r, z, lat, ok);
        total++;
        if (!ok || q !== 32'd14 || r !== 32'd2 || z !== 1'b0 || lat !== 8) begin
            bad++;
            $display("FAIL steps4_w32: q=%h r=%h z=%b lat=%0d, want q=0000000e r=00000002 z=0 lat=8",
                     q, r, z, lat);
        end
        run_op(3, 1'b0, 32'd100, 32'd7, q, r, z, lat, ok);
        total++;
        if (!ok || q !== 32'd14 || r !== 32'd2 || z !== 1'b0 || lat !== 2) begin
            bad++;
            $display("FAIL steps4_w8: q=%h r=%h z=%b lat=%0d, want q=0000000e r=00000002 z=0 lat=2",
                     q, r, z, lat);
        end
    endtask

    task automatic test_random(input int s, input int count);
        logic [31:0] a, b, q, r, eq, er, mask;
        logic        z, ez, sg, ok;
        int          lat, elat, w, errs;
        w    = wid(s);
        mask = (w == 32) ? 32'hFFFFFFFF : 32'h000000FF;
        errs = 0;
        for (int i = 0; i < count; i++) begin
            a  = $urandom;
            b  = $urandom;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h1 << (w - 1);
                3: b = $urandom_range(1, 15);
                4: begin a = 32'h1 << (w - 1); b = 32'hFFFFFFFF; end
                5: b = b >> $urandom_range(0, w - 1);
                default: ;
            endcase
            a = a & mask;
            b = b & mask;
            ref_div(w, sg, a, b, eq, er, ez);
            elat = (b == 32'h0) ? 1 : iters(s);
            run_op(s, sg, a, b, q, r, z, lat, ok);
            total++;
            if (!ok || q !== eq || r !== er || z !== ez || lat !== elat) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_dut%0d: sg=%b a=%h b=%h got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                             s, sg, a, b, q, r, z, lat, eq, er, ez, elat);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int s = 0; s < 4; s++) begin
            drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
            set_ordy(s, 1'b0);
        end
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_steps4();
        test_random(0, 200);
        test_random(1, 1000);
        test_random(2, 1000);
        test_random(3, 2000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
